slot_machine_core: RTL and testbench



---
 rtl/slot_pkg.sv | 27 ++
 rtl/slot_machine_core_if.sv | 31 +++
 rtl/slot_reel.sv | 40 ++++
 rtl/slot_machine_core.sv | 227 ++++++++++++++++++++++
 tb/tb_slot_machine_core.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types and helpers for the slot machine core.
// No timing of its own: the function below is purely combinational.
// No handshakes or backpressure are involved.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPIN     = 3'd1,
        STOPPING = 3'd2,
        EVAL     = 3'd3,
        RESULT   = 3'd4
    } state_t;

    // Returns a + b, clamped to max_val. The sum is one bit wider so the clamp still works at the top of the range.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            sat_add = max_val;
        end else begin
            sat_add = sum[31:0];
        end
    endfunction

endpackage

// File: rtl/slot_machine_core_if.sv
// Button/credit inputs and display/buzzer outputs of the slot machine core.
// Latency is set by the core; the interface itself only carries the signals.
// No backpressure: inputs are levels or single-cycle pulses.
// Ports (slave = core side): start_stop, credit_in in; reels, state, win, pair_win, credits, buzzer out.
interface slot_machine_core_if #(
    parameter int NUM_REELS = 3,
    parameter int SYM_W     = 4,
    parameter int CREDIT_W  = 8
);
    import slot_pkg::*;

    logic                       start_stop;
    logic                       credit_in;
    logic [NUM_REELS*SYM_W-1:0] reels;
    state_t                     state;
    logic                       win;
    logic                       pair_win;
    logic [CREDIT_W-1:0]        credits;
    logic                       buzzer;

    modport master (
        output start_stop, credit_in,
        input  reels, state, win, pair_win, credits, buzzer
    );

    modport slave (
        input  start_stop, credit_in,
        output reels, state, win, pair_win, credits, buzzer
    );

endinterface

// File: rtl/slot_reel.sv
// One reel: a divider that advances the symbol value once every PERIOD running cycles.
// Latency: the value updates on the clock edge where the divider reaches its terminal count.
// No backpressure; i_freeze holds the value and the divider for the current edge.
// Ports: i_clk, i_rst, i_clear_div, i_run, i_freeze in; o_value out.
module slot_reel #(
    parameter int PERIOD      = 4,
    parameter int NUM_SYMBOLS = 10,
    parameter int SYM_W       = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear_div,
    input  logic             i_run,
    input  logic             i_freeze,
    output logic [SYM_W-1:0] o_value
);
    localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [DIV_W-1:0] r_div;
    logic [SYM_W-1:0] r_value;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div   <= '0;
            r_value <= '0;
        end else if (i_clear_div) begin
            r_div <= '0;
        end else if (i_run && !i_freeze) begin
            if (r_div == DIV_W'(PERIOD - 1)) begin
                r_div   <= '0;
                r_value <= (r_value == SYM_W'(NUM_SYMBOLS - 1)) ? '0 : r_value + SYM_W'(1);
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/slot_machine_core.sv
// Slot machine game core: N reels, staggered stopping, credit accounting, payout and buzzer.
// Latency: a start edge changes state on the next cycle; EVAL lasts one cycle, then RESULT.
// No backpressure; start edges are ignored while STOPPING and while IDLE with zero credits.
// Ports: i_clk, i_rst (sync, active high); io_bus (slave modport of slot_machine_core_if).
module slot_machine_core
    import slot_pkg::*;
#(
    parameter int NUM_REELS    = 3,
    parameter int NUM_SYMBOLS  = 10,
    parameter int DIV_BASE     = 4,
    parameter int STOP_GAP     = 8,
    parameter int CREDIT_W     = 8,
    parameter int INIT_CREDITS = 3,
    parameter int JACKPOT_PAY  = 10,
    parameter int PAIR_PAY     = 2,
    parameter int BUZZ_CYCLES  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    slot_machine_core_if.slave io_bus
);
    localparam int SYM_W  = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
    localparam int GAP_W  = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
    localparam int IDX_W  = $clog2(NUM_REELS);
    localparam int BUZZ_W = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;
    localparam logic [CREDIT_W-1:0] CRED_MAX = '1;

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       r_start_d;
    logic [NUM_REELS-1:0]       r_frozen;
    logic [GAP_W-1:0]           r_gap;
    logic [IDX_W-1:0]           r_next;
    logic [CREDIT_W-1:0]        r_credits;
    logic                       r_win;
    logic                       r_pair;
    logic [BUZZ_W-1:0]          r_buzz_cnt;

    logic                       w_start_edge;
    logic                       w_has_credit;
    logic                       w_run;
    logic                       w_charge;
    logic                       w_clear_div;
    logic                       w_clear_flags;
    logic                       w_stop_hit;
    logic                       w_gap_hit;
    logic [NUM_REELS-1:0]       w_freeze;
    logic                       w_all_eq;
    logic                       w_pair_eq;
    logic [31:0]                w_pay;
    logic [CREDIT_W-1:0]        w_credit_nxt;
    logic [SYM_W-1:0]           w_val [NUM_REELS];
    logic [NUM_REELS*SYM_W-1:0] w_reels;

    assign w_start_edge = io_bus.start_stop & ~r_start_d;
    assign w_has_credit = (r_credits != '0);
    assign w_run        = (r_state == SPIN) || (r_state == STOPPING);

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and control strobes
    always_comb begin
        w_next_state  = r_state;
        w_charge      = 1'b0;
        w_clear_div   = 1'b0;
        w_clear_flags = 1'b0;
        w_stop_hit    = 1'b0;
        w_gap_hit     = 1'b0;
        case (r_state)
            IDLE, RESULT: begin
                if (w_start_edge) begin
                    w_clear_flags = 1'b1;
                    if (w_has_credit) begin
                        w_charge     = 1'b1;
                        w_clear_div  = 1'b1;
                        w_next_state = SPIN;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            SPIN: begin
                if (w_start_edge) begin
                    w_stop_hit   = 1'b1;
                    w_next_state = STOPPING;
                end
            end
            STOPPING: begin
                // The cycle after the last freeze is spent here so every reel has settled before EVAL compares.
                if (&r_frozen) begin
                    w_next_state = EVAL;
                end else if (r_gap == GAP_W'(STOP_GAP - 1)) begin
                    w_gap_hit = 1'b1;
                end
            end
            EVAL: begin
                w_next_state = RESULT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A reel is held on the very edge that freezes it, so it keeps the value shown in that cycle.
    always_comb begin
        w_freeze = r_frozen;
        if (w_stop_hit) begin
            w_freeze[0] = 1'b1;
        end
        for (int i = 1; i < NUM_REELS; i++) begin
            if (w_gap_hit && (r_next == IDX_W'(i))) begin
                w_freeze[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
        slot_reel #(
            .PERIOD      (DIV_BASE * (g + 1)),
            .NUM_SYMBOLS (NUM_SYMBOLS),
            .SYM_W       (SYM_W)
        ) u_reel (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_clear_div (w_clear_div),
            .i_run       (w_run),
            .i_freeze    (w_freeze[g]),
            .o_value     (w_val[g])
        );
        assign w_reels[g*SYM_W +: SYM_W] = w_val[g];
    end

    always_comb begin
        w_all_eq = 1'b1;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (w_val[i] != w_val[0]) begin
                w_all_eq = 1'b0;
            end
        end
    end

    assign w_pair_eq = (w_val[1] == w_val[0]);

    // Payout and coin insertion go through one saturating add; a charge only happens with credits > 0.
    always_comb begin
        w_pay = 32'd0;
        if (r_state == EVAL) begin
            if (w_all_eq) begin
                w_pay = 32'(JACKPOT_PAY);
            end else if (w_pair_eq) begin
                w_pay = 32'(PAIR_PAY);
            end
        end
        w_credit_nxt = r_credits;
        if (w_charge) begin
            if (!io_bus.credit_in) begin
                w_credit_nxt = r_credits - CREDIT_W'(1);
            end
        end else begin
            w_credit_nxt = CREDIT_W'(sat_add(32'(r_credits),
                                             w_pay + 32'(io_bus.credit_in),
                                             32'(CRED_MAX)));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_start_d  <= 1'b0;
            r_frozen   <= '0;
            r_gap      <= '0;
            r_next     <= '0;
            r_credits  <= CREDIT_W'(INIT_CREDITS);
            r_win      <= 1'b0;
            r_pair     <= 1'b0;
            r_buzz_cnt <= '0;
        end else begin
            r_start_d <= io_bus.start_stop;
            r_credits <= w_credit_nxt;

            if (w_clear_div) begin
                r_frozen <= '0;
            end else begin
                r_frozen <= w_freeze;
            end

            if (w_stop_hit) begin
                r_gap  <= '0;
                r_next <= IDX_W'(1);
            end else if (r_state == STOPPING) begin
                if (w_gap_hit) begin
                    r_gap  <= '0;
                    r_next <= r_next + IDX_W'(1);
                end else begin
                    r_gap <= r_gap + GAP_W'(1);
                end
            end

            if (r_state == EVAL) begin
                r_win      <= w_all_eq;
                r_pair     <= !w_all_eq && w_pair_eq;
                r_buzz_cnt <= w_all_eq ? BUZZ_W'(BUZZ_CYCLES) : '0;
            end else if (w_clear_flags) begin
                r_win      <= 1'b0;
                r_pair     <= 1'b0;
                r_buzz_cnt <= '0;
            end else if (r_buzz_cnt != '0) begin
                r_buzz_cnt <= r_buzz_cnt - BUZZ_W'(1);
            end
        end
    end

    assign io_bus.reels    = w_reels;
    assign io_bus.state    = r_state;
    assign io_bus.win      = r_win;
    assign io_bus.pair_win = r_pair;
    assign io_bus.credits  = r_credits;
    assign io_bus.buzzer   = (r_buzz_cnt != '0);

endmodule

// File: tb/tb_slot_machine_core.sv
// Self-checking bench for slot_machine_core: directed vector table, randomized run against a game model,
// and short sequences on parameter variants (single symbol, zero credits, narrow credit counter).
module tb_slot_machine_core;
    import slot_pkg::*;

    localparam int N    = 3;
    localparam int NS   = 10;
    localparam int DIV  = 4;
    localparam int GAP  = 8;
    localparam int INIT = 3;
    localparam int JP   = 10;
    localparam int PP   = 2;
    localparam int BZ   = 16;
    localparam int SW   = 4;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    slot_machine_core_if #(.NUM_REELS(3), .SYM_W(4), .CREDIT_W(8)) if0 ();
    slot_machine_core_if #(.NUM_REELS(3), .SYM_W(1), .CREDIT_W(8)) if1 ();
    slot_machine_core_if #(.NUM_REELS(3), .SYM_W(4), .CREDIT_W(8)) if2 ();
    slot_machine_core_if #(.NUM_REELS(3), .SYM_W(1), .CREDIT_W(4)) if3 ();

    slot_machine_core dut0 (.i_clk(clk), .i_rst(rst0), .io_bus(if0.slave));
    slot_machine_core #(.NUM_SYMBOLS(1)) dut1 (.i_clk(clk), .i_rst(rst1), .io_bus(if1.slave));
    slot_machine_core #(.INIT_CREDITS(0)) dut2 (.i_clk(clk), .i_rst(rst2), .io_bus(if2.slave));
    slot_machine_core #(.NUM_SYMBOLS(1), .CREDIT_W(4), .INIT_CREDITS(15)) dut3 (.i_clk(clk), .i_rst(rst1), .io_bus(if3.slave));

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- game model (event/arithmetic level) ----------------
    state_t m_st;
    int     m_cred;
    bit     m_win, m_pair, m_prev;
    int     m_buzz, m_t;
    int     m_base [N];
    int     m_n    [N];   // advancing cycles since the dividers were last cleared

    function automatic int m_val(input int i);
        return (m_base[i] + m_n[i] / (DIV * (i + 1))) % NS;
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic m_step(input bit r, input bit ss, input bit ci);
        bit ed;
        bit all_eq;
        ed = ss && !m_prev;
        m_prev = ss;
        if (r) begin
            m_st = IDLE; m_cred = INIT; m_win = 0; m_pair = 0; m_buzz = 0; m_t = 0; m_prev = 0;
            for (int i = 0; i < N; i++) begin m_base[i] = 0; m_n[i] = 0; end
            return;
        end
        case (m_st)
            IDLE, RESULT: begin
                if (m_buzz > 0) m_buzz--;
                if (ed) begin
                    m_win = 0; m_pair = 0; m_buzz = 0;
                    if (m_cred > 0) begin
                        m_cred = m_cred - 1 + int'(ci);
                        for (int i = 0; i < N; i++) begin m_base[i] = m_val(i); m_n[i] = 0; end
                        m_st = SPIN;
                    end else begin
                        m_cred = sat(m_cred + int'(ci));
                        m_st = IDLE;
                    end
                end else begin
                    m_cred = sat(m_cred + int'(ci));
                end
            end
            SPIN: begin
                m_cred = sat(m_cred + int'(ci));
                for (int i = 0; i < N; i++) if (!(ed && i == 0)) m_n[i]++;
                if (ed) begin m_st = STOPPING; m_t = 0; end
            end
            STOPPING: begin
                m_cred = sat(m_cred + int'(ci));
                m_t++;
                // reel i freezes i*GAP cycles after the stop edge
                for (int i = 1; i < N; i++) if (m_t < i * GAP) m_n[i]++;
                if (m_t == (N - 1) * GAP + 1) m_st = EVAL;
            end
            EVAL: begin
                all_eq = 1;
                for (int i = 1; i < N; i++) if (m_val(i) != m_val(0)) all_eq = 0;
                if (all_eq) begin
                    m_win = 1; m_buzz = BZ; m_cred = sat(m_cred + int'(ci) + JP);
                end else if (m_val(0) == m_val(1)) begin
                    m_pair = 1; m_cred = sat(m_cred + int'(ci) + PP);
                end else begin
                    m_cred = sat(m_cred + int'(ci));
                end
                m_st = RESULT;
            end
            default: m_st = IDLE;
        endcase
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] p;
        p = 64'(m_st) << 32 | 64'(m_cred) << 16 | 64'(m_win) << 2 | 64'(m_pair) << 1 | 64'(m_buzz > 0);
        for (int i = 0; i < N; i++) p = p | (64'(m_val(i)) << (4 + i * SW));
        return p;
    endfunction

    function automatic logic [63:0] d_pack();
        return 64'(if0.state) << 32 | 64'(if0.credits) << 16 | 64'(if0.reels) << 4 |
               64'(if0.win) << 2 | 64'(if0.pair_win) << 1 | 64'(if0.buzzer);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        int     cyc;
        logic   ss;
        logic   ci;
        state_t st;
        int     cred, r0, r1, r2, win, pair;
    } vec_t;

    vec_t vt [18];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_j(input logic ss, input logic ci);
        if1.start_stop = ss; if1.credit_in = ci;
        if3.start_stop = ss; if3.credit_in = ci;
    endtask

    initial begin
        int bcnt;
        bit r, ss, ci;

        vt[0]  = '{1,   1'b0, 1'b0, IDLE,     3, 0, 0, 0, 0, 0};
        vt[1]  = '{1,   1'b1, 1'b0, SPIN,     2, 0, 0, 0, 0, 0};
        vt[2]  = '{3,   1'b1, 1'b0, SPIN,     2, 0, 0, 0, 0, 0};
        vt[3]  = '{1,   1'b1, 1'b0, SPIN,     2, 1, 0, 0, 0, 0};
        vt[4]  = '{4,   1'b1, 1'b0, SPIN,     2, 2, 1, 0, 0, 0};
        vt[5]  = '{4,   1'b1, 1'b0, SPIN,     2, 3, 1, 1, 0, 0};
        vt[6]  = '{28,  1'b1, 1'b0, SPIN,     2, 0, 5, 3, 0, 0};
        vt[7]  = '{1,   1'b0, 1'b0, SPIN,     2, 0, 5, 3, 0, 0};
        vt[8]  = '{1,   1'b1, 1'b0, STOPPING, 2, 0, 5, 3, 0, 0};
        vt[9]  = '{7,   1'b1, 1'b0, STOPPING, 2, 0, 6, 4, 0, 0};
        vt[10] = '{1,   1'b1, 1'b0, STOPPING, 2, 0, 6, 4, 0, 0};
        vt[11] = '{8,   1'b1, 1'b0, STOPPING, 2, 0, 6, 4, 0, 0};
        vt[12] = '{1,   1'b1, 1'b0, EVAL,     2, 0, 6, 4, 0, 0};
        vt[13] = '{1,   1'b1, 1'b0, RESULT,   2, 0, 6, 4, 0, 0};
        vt[14] = '{100, 1'b1, 1'b0, RESULT,   2, 0, 6, 4, 0, 0};
        vt[15] = '{1,   1'b0, 1'b0, RESULT,   2, 0, 6, 4, 0, 0};
        vt[16] = '{1,   1'b1, 1'b1, SPIN,     2, 0, 6, 4, 0, 0};
        vt[17] = '{4,   1'b1, 1'b0, SPIN,     2, 1, 6, 4, 0, 0};

        rst0 = 1; rst1 = 1; rst2 = 1;
        if0.start_stop = 0; if0.credit_in = 0;
        drive_j(0, 0);
        if2.start_stop = 0; if2.credit_in = 0;
        tick(2);
        rst0 = 0; rst1 = 0; rst2 = 0;

        // ---- vector table on the default configuration ----
        rst0 = 1; tick(1); rst0 = 0;
        for (int k = 0; k < 18; k++) begin
            if0.start_stop = vt[k].ss;
            if0.credit_in  = vt[k].ci;
            tick(vt[k].cyc);
            if0.credit_in  = 0;
            chk($sformatf("vec%0d state", k),   64'(if0.state),            64'(vt[k].st));
            chk($sformatf("vec%0d credits", k), 64'(if0.credits),          64'(vt[k].cred));
            chk($sformatf("vec%0d reel0", k),   64'(if0.reels[0 +: 4]),    64'(vt[k].r0));
            chk($sformatf("vec%0d reel1", k),   64'(if0.reels[4 +: 4]),    64'(vt[k].r1));
            chk($sformatf("vec%0d reel2", k),   64'(if0.reels[8 +: 4]),    64'(vt[k].r2));
            chk($sformatf("vec%0d win", k),     64'(if0.win),              64'(vt[k].win));
            chk($sformatf("vec%0d pair", k),    64'(if0.pair_win),         64'(vt[k].pair));
        end

        // ---- randomized run against the model ----
        ss = 0;
        for (int c = 0; c < 3000; c++) begin
            r  = (c == 0) || ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 4) == 0) ss = ~ss;
            ci = ($urandom_range(0, 19) == 0);
            rst0 = r; if0.start_stop = ss; if0.credit_in = ci;
            m_step(r, ss, ci);
            tick(1);
            chk($sformatf("rand cyc%0d", c), d_pack(), m_pack());
        end
        rst0 = 0; if0.credit_in = 0;

        // ---- reset in the middle of STOPPING ----
        if0.start_stop = 0; rst0 = 1; tick(1); rst0 = 0; tick(1);
        if0.start_stop = 1; tick(1);
        chk("abort spin state", 64'(if0.state), 64'(SPIN));
        if0.start_stop = 0; tick(3);
        if0.start_stop = 1; tick(1);
        chk("abort stopping state", 64'(if0.state), 64'(STOPPING));
        tick(3);
        rst0 = 1; tick(1); rst0 = 0; if0.start_stop = 0;
        chk("abort state", 64'(if0.state), 64'(IDLE));
        chk("abort reels", 64'(if0.reels), 64'd0);
        chk("abort credits", 64'(if0.credits), 64'(INIT));
        chk("abort buzzer", 64'(if0.buzzer), 64'd0);
        tick(20);
        chk("abort no payout", 64'(if0.credits), 64'(INIT));
        chk("abort stays idle", 64'(if0.state), 64'(IDLE));

        // ---- single-symbol jackpot (dut1) and narrow saturating credits (dut3) ----
        drive_j(0, 0); rst1 = 1; tick(1); rst1 = 0;
        chk("jp reset state", 64'(if1.state), 64'(IDLE));
        chk("jp reset credits", 64'(if1.credits), 64'd3);
        chk("sat reset credits", 64'(if3.credits), 64'd15);
        drive_j(1, 0); tick(1);
        chk("jp spin", 64'(if1.state), 64'(SPIN));
        chk("jp charge", 64'(if1.credits), 64'd2);
        chk("sat charge", 64'(if3.credits), 64'd14);
        drive_j(0, 0); tick(1);
        drive_j(1, 0); tick(1);
        chk("jp stopping", 64'(if1.state), 64'(STOPPING));
        tick(16);
        chk("jp still stopping", 64'(if1.state), 64'(STOPPING));
        tick(1);
        chk("jp eval", 64'(if1.state), 64'(EVAL));
        tick(1);
        chk("jp result", 64'(if1.state), 64'(RESULT));
        chk("jp win", 64'(if1.win), 64'd1);
        chk("jp pair", 64'(if1.pair_win), 64'd0);
        chk("jp credits", 64'(if1.credits), 64'd12);
        chk("sat payout", 64'(if3.credits), 64'd15);
        chk("sat win", 64'(if3.win), 64'd1);
        bcnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (if1.buzzer === 1'b1) bcnt++;
            tick(1);
        end
        chk("jp buzzer cycles", 64'(bcnt), 64'(BZ));
        chk("jp win held", 64'(if1.win), 64'd1);
        drive_j(1, 1); tick(1); drive_j(1, 0);
        chk("jp coin", 64'(if1.credits), 64'd13);
        chk("sat coin", 64'(if3.credits), 64'd15);
        drive_j(0, 0); tick(1);
        drive_j(1, 0); tick(1);
        chk("jp restart state", 64'(if1.state), 64'(SPIN));
        chk("jp restart credits", 64'(if1.credits), 64'd12);
        chk("jp restart win clr", 64'(if1.win), 64'd0);
        chk("jp restart buzz clr", 64'(if1.buzzer), 64'd0);

        // ---- zero credits (dut2) ----
        if2.start_stop = 0; if2.credit_in = 0; rst2 = 1; tick(1); rst2 = 0;
        if2.start_stop = 1; tick(1);
        chk("zero ignore start", 64'(if2.state), 64'(IDLE));
        chk("zero credits", 64'(if2.credits), 64'd0);
        if2.start_stop = 0; if2.credit_in = 1; tick(1); if2.credit_in = 0;
        chk("zero coin", 64'(if2.credits), 64'd1);
        chk("zero coin idle", 64'(if2.state), 64'(IDLE));
        if2.start_stop = 1; tick(1);
        chk("zero start spin", 64'(if2.state), 64'(SPIN));
        chk("zero start credits", 64'(if2.credits), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
